data_bus_sync: RTL and testbench

- Destination-domain synchronizer for a multi-bit bus crossing from another clock domain, qualified by a single-bit enable.
- Passes the enable through a NUM_STAGES flop chain, detects its rising edge, captures the stable bus on that edge, and emits a one-cycle enable pulse.
- Sits between the UART RX front end and the system-domain control FSM, next to the reset synchronizers.
- Handles the bus data crossing; the reset synchronizers handle reset release only.

---
 rtl/cdc_pkg.sv | 10 +
 rtl/sync_chain.sv | 36 +++
 rtl/data_bus_sync.sv | 90 +++++++++
 tb/tb_data_bus_sync.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants for clock-domain-crossing blocks: default widths and legal
// synchronizer depth range.
package cdc_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int BUS_WIDTH_DEF   = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// Generic 1-bit multi-flop synchronizer with synchronous active-low clear.
// q is the last stage; d is sampled into stage 0 every clk.
module sync_chain
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Too few stages defeats metastability settling; too many only adds latency.
  if ((NUM_STAGES < SYNC_STAGES_MIN) || (NUM_STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $error("sync_chain: NUM_STAGES out of legal range");
  end

  logic [NUM_STAGES-1:0] stage_q;
  logic [NUM_STAGES-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[NUM_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_bus_sync.sv
// Destination-domain bus synchronizer: syncs the enable, captures the bus on its
// rising edge and emits a one-clk pulse. Optional toggle ack via DATA_BUS_SYNC_ACK_EN.
module data_bus_sync
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = SYNC_STAGES_DEF,
  parameter int BUS_WIDTH  = BUS_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 unsync_bus_en,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse
`ifdef DATA_BUS_SYNC_ACK_EN
  ,
  output logic                 bus_ack
`endif
);

  logic                 synced_en;
  logic                 rising;
  logic                 pulse_ff_q;
  logic                 pulse_ff_d;
  logic                 enable_pulse_q;
  logic                 enable_pulse_d;
  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [BUS_WIDTH-1:0] sync_bus_d;

  sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_en_sync (
    .clk(clk),
    .rst(rst),
    .d  (unsync_bus_en),
    .q  (synced_en)
  );

  // The bus is only sampled on the synced rising edge, when it is guaranteed stable.
  always_comb begin
    rising         = synced_en & ~pulse_ff_q;
    pulse_ff_d     = synced_en;
    enable_pulse_d = rising;
    if (rising) begin
      sync_bus_d = unsync_bus;
    end else begin
      sync_bus_d = sync_bus_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pulse_ff_q     <= 1'b0;
      enable_pulse_q <= 1'b0;
      sync_bus_q     <= '0;
    end else begin
      pulse_ff_q     <= pulse_ff_d;
      enable_pulse_q <= enable_pulse_d;
      sync_bus_q     <= sync_bus_d;
    end
  end

  assign sync_bus     = sync_bus_q;
  assign enable_pulse = enable_pulse_q;

`ifdef DATA_BUS_SYNC_ACK_EN
  logic bus_ack_q;
  logic bus_ack_d;

  // Toggle per delivered word; the source resynchronizes this and compares levels.
  always_comb begin
    if (enable_pulse_q) begin
      bus_ack_d = ~bus_ack_q;
    end else begin
      bus_ack_d = bus_ack_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_ack_q <= 1'b0;
    end else begin
      bus_ack_q <= bus_ack_d;
    end
  end

  assign bus_ack = bus_ack_q;
`endif

endmodule

// File: tb/tb_data_bus_sync.sv
// Directed self-checking bench for data_bus_sync (3 stages and ack test when
// DATA_BUS_SYNC_ACK_EN is defined, otherwise 2 stages).
module tb_data_bus_sync;

`ifdef DATA_BUS_SYNC_ACK_EN
  localparam int NS = 3;
`else
  localparam int NS = 2;
`endif
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [BW-1:0] unsync_bus = 8'h00;
  logic          unsync_bus_en = 1'b0;
  logic [BW-1:0] sync_bus;
  logic          enable_pulse;
`ifdef DATA_BUS_SYNC_ACK_EN
  logic          bus_ack;
`endif

  int checks = 0;
  int failures = 0;

  data_bus_sync #(
    .NUM_STAGES(NS),
    .BUS_WIDTH (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .unsync_bus   (unsync_bus),
    .unsync_bus_en(unsync_bus_en),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse)
`ifdef DATA_BUS_SYNC_ACK_EN
    ,
    .bus_ack      (bus_ack)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    unsync_bus_en = 1'b1;
    unsync_bus = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sync_bus !== 8'h00) begin
        failures++;
        $display("FAIL reset_bus cycle %0d: got %h expected 00", i, sync_bus);
      end
      checks++;
      if (enable_pulse !== 1'b0) begin
        failures++;
        $display("FAIL reset_pulse cycle %0d: got %b expected 0", i, enable_pulse);
      end
    end
    unsync_bus_en = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < NS + 2; i++) begin
      tick();
      checks++;
      if (enable_pulse !== 1'b0) begin
        failures++;
        $display("FAIL idle_pulse cycle %0d: got %b expected 0", i, enable_pulse);
      end
    end
  endtask

  task automatic test_single();
    unsync_bus = 8'hA5;
    unsync_bus_en = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (enable_pulse !== (e == NS + 1)) begin
        failures++;
        $display("FAIL single_pulse edge %0d: got %b expected %b", e, enable_pulse, (e == NS + 1));
      end
      checks++;
      if (sync_bus !== ((e >= NS + 1) ? 8'hA5 : 8'h00)) begin
        failures++;
        $display("FAIL single_bus edge %0d: got %h", e, sync_bus);
      end
    end
  endtask

  task automatic test_hold();
    unsync_bus = 8'h3C;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (enable_pulse !== 1'b0) begin
        failures++;
        $display("FAIL hold_pulse edge %0d: got %b expected 0", e, enable_pulse);
      end
      checks++;
      if (sync_bus !== 8'hA5) begin
        failures++;
        $display("FAIL hold_bus edge %0d: got %h expected a5", e, sync_bus);
      end
    end
  endtask

  task automatic test_back_to_back();
    unsync_bus_en = 1'b0;
    tick();
    unsync_bus_en = 1'b1;
    unsync_bus = 8'h5A;
    for (int e = 1; e <= NS + 4; e++) begin
      tick();
      checks++;
      if (enable_pulse !== (e == NS + 1)) begin
        failures++;
        $display("FAIL b2b_pulse edge %0d: got %b expected %b", e, enable_pulse, (e == NS + 1));
      end
      checks++;
      if (sync_bus !== ((e >= NS + 1) ? 8'h5A : 8'hA5)) begin
        failures++;
        $display("FAIL b2b_bus edge %0d: got %h", e, sync_bus);
      end
    end
  endtask

  task automatic test_glitch();
    unsync_bus_en = 1'b0;
    for (int i = 0; i < NS + 2; i++) tick();
    unsync_bus = 8'hC3;
    unsync_bus_en = 1'b1;
    tick();
    unsync_bus_en = 1'b0;
    checks++;
    if (enable_pulse !== 1'b0) begin
      failures++;
      $display("FAIL glitch_pulse edge 1: got %b expected 0", enable_pulse);
    end
    for (int e = 2; e <= NS + 4; e++) begin
      tick();
      checks++;
      if (enable_pulse !== (e == NS + 1)) begin
        failures++;
        $display("FAIL glitch_pulse edge %0d: got %b expected %b", e, enable_pulse, (e == NS + 1));
      end
    end
    checks++;
    if (sync_bus !== 8'hC3) begin
      failures++;
      $display("FAIL glitch_bus: got %h expected c3", sync_bus);
    end
  endtask

  task automatic test_reset_mid();
    unsync_bus_en = 1'b0;
    for (int i = 0; i < NS + 2; i++) tick();
    unsync_bus = 8'h11;
    unsync_bus_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (enable_pulse !== 1'b0) begin
      failures++;
      $display("FAIL midrst_pulse: got %b expected 0", enable_pulse);
    end
    checks++;
    if (sync_bus !== 8'h00) begin
      failures++;
      $display("FAIL midrst_bus: got %h expected 00", sync_bus);
    end
    rst = 1'b1;
    for (int e = 1; e <= NS + 3; e++) begin
      tick();
      checks++;
      if (enable_pulse !== (e == NS + 1)) begin
        failures++;
        $display("FAIL midrst_relpulse edge %0d: got %b expected %b", e, enable_pulse, (e == NS + 1));
      end
      checks++;
      if (sync_bus !== ((e >= NS + 1) ? 8'h11 : 8'h00)) begin
        failures++;
        $display("FAIL midrst_relbus edge %0d: got %h", e, sync_bus);
      end
    end
  endtask

`ifdef DATA_BUS_SYNC_ACK_EN
  task automatic test_ack();
    logic [7:0] vals [3];
    logic       exp_ack;
    vals[0] = 8'h01;
    vals[1] = 8'h02;
    vals[2] = 8'h03;
    exp_ack = 1'b0;
    unsync_bus_en = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (bus_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_reset: got %b expected 0", bus_ack);
    end
    for (int t = 0; t < 3; t++) begin
      unsync_bus_en = 1'b0;
      for (int i = 0; i < NS + 2; i++) tick();
      unsync_bus = vals[t];
      unsync_bus_en = 1'b1;
      for (int e = 1; e <= NS + 2; e++) begin
        tick();
        checks++;
        if (enable_pulse !== (e == NS + 1)) begin
          failures++;
          $display("FAIL ack_pulse xfer %0d edge %0d: got %b", t, e, enable_pulse);
        end
        // ack flips on the edge after the pulse is registered
        if (e == NS + 2) exp_ack = ~exp_ack;
        checks++;
        if (bus_ack !== exp_ack) begin
          failures++;
          $display("FAIL ack_level xfer %0d edge %0d: got %b expected %b", t, e, bus_ack, exp_ack);
        end
      end
      checks++;
      if (sync_bus !== vals[t]) begin
        failures++;
        $display("FAIL ack_bus xfer %0d: got %h expected %h", t, sync_bus, vals[t]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
`ifdef DATA_BUS_SYNC_ACK_EN
    test_ack();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
